seg_display_mux: RTL and testbench

Parametrised time-multiplexed driver for a common-anode/cathode seven-segment display bank. It generalises the fixed 4-digit hex scanner to N digits, with double-buffered frame-atomic data updates, per-digit decimal points, leading-zero suppression, PWM brightness control and selectable output polarity. It sits between the board's display pins and any logic that produces a packed hex value, for example a UART receive path or debug counters.

---
 rtl/seg_display_mux.sv | 119 +++++++++++
 tb/tb_seg_display_mux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed N-digit seven-segment driver with frame-atomic buffering.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   data, dp, load     packed hex nibbles / decimal points, captured into the shadow buffer on load
//   blank_lz           suppress segments of leading zero digits
//   brightness         on-time per slot, in units of 2^(DIV_W-BRIGHT_W) cycles
//   anodes, seg        registered digit enables and segments (bit7 = dp), polarity per parameters
//   frame_done         one-cycle pulse after each frame wrap
module seg_display_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int DIV_W            = 13,
    parameter int BRIGHT_W         = 2,
    parameter bit ANODE_ACTIVE_LOW = 1'b0,
    parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              seg,
    output logic                    frame_done
);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d, disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d, act;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;
    logic                    slot_end, wrap, on, dp_bit;
    logic [3:0]              nib;
    logic [IDX_W-1:0]        lead;
    logic [6:0]              glyph;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        slot_end      = &cnt_q;
        wrap          = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d         = cnt_q + 1'b1;
        idx_d         = slot_end ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        shadow_data_d = load ? data : shadow_data_q;
        shadow_dp_d   = load ? dp : shadow_dp_q;
        // Taking the shadow's next value gives the load-at-wrap bypass for free.
        disp_data_d   = wrap ? shadow_data_d : disp_data_q;
        disp_dp_d     = wrap ? shadow_dp_d : disp_dp_q;
        on            = cnt_q[DIV_W-1 -: BRIGHT_W] < brightness;
        nib           = '0;
        dp_bit        = 1'b0;
        lead          = '0;
        act           = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib    = disp_data_q[4*i +: 4];
                dp_bit = disp_dp_q[i];
            end
            if (disp_data_q[4*i +: 4] != 4'h0) lead = IDX_W'(i);
            act[i] = on && (idx_q == IDX_W'(i));
        end
        // lead is 0 when all digits are zero, so digit 0 is never suppressed.
        glyph         = (blank_lz && idx_q > lead) ? 7'h00 : hex7(nib);
        anodes_d      = act ^ {NUM_DIGITS{ANODE_ACTIVE_LOW}};
        seg_d         = (on ? {dp_bit, glyph} : 8'h00) ^ {8{SEG_ACTIVE_LOW}};
        frame_done_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            anodes_q      <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
            seg_q         <= {8{SEG_ACTIVE_LOW}};
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            anodes_q      <= anodes_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign anodes     = anodes_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: randomized scoreboard bench for seg_display_mux (4-digit and inverted 3-digit builds).
module tb_seg_display_mux;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  an0;
    logic [7:0]  seg0, seg1;
    logic [2:0]  an1;
    logic        fd0, fd1;

    typedef struct packed {
        logic [3:0] an0;
        logic [7:0] seg0;
        logic       fd0;
        logic [2:0] an1;
        logic [7:0] seg1;
        logic       fd1;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0, t = 0;
    logic [15:0] sh_d = '0;
    logic [3:0]  sh_p = '0;
    logic [15:0] dd[2];
    logic [3:0]  ddp[2];
    logic [6:0]  glyph[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_mux #(.NUM_DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank_lz(blank_lz),
        .brightness(brightness), .anodes(an0), .seg(seg0), .frame_done(fd0));

    seg_display_mux #(.NUM_DIGITS(3), .DIV_W(4), .BRIGHT_W(2), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst(rst), .data(data[11:0]), .dp(dp[2:0]), .load(load), .blank_lz(blank_lz),
        .brightness(brightness), .anodes(an1), .seg(seg1), .frame_done(fd1));

    always #5 clk = ~clk;

    // Reference: position in the scan derives from cycles since reset; frames are 16*n cycles long.
    function automatic logic [12:0] expect_out(input int k);
        int n, cnt, idx, m;
        logic on;
        logic [6:0] g;
        logic [3:0] an;
        logic [7:0] sg;
        n   = (k == 1) ? 3 : 4;
        cnt = t % 16;
        idx = (t / 16) % n;
        m   = 0;
        on  = (cnt / 4) < int'(brightness);
        for (int i = 0; i < n; i++) if (dd[k][4*i +: 4] != 4'h0) m = i;
        g   = (blank_lz && idx > m) ? 7'h00 : glyph[dd[k][4*idx +: 4]];
        an  = on ? 4'(1 << idx) : 4'h0;
        sg  = on ? {ddp[k][idx], g} : 8'h00;
        if (k == 1) begin
            an = an ^ 4'b0111;
            sg = ~sg;
        end
        return {(t % (16*n)) == (16*n - 1), an, sg};
    endfunction

    task automatic model_step();
        exp_t e;
        logic [12:0] r0, r1;
        if (rst) begin
            e.an0 = 4'h0; e.seg0 = 8'h00; e.fd0 = 1'b0;
            e.an1 = 3'b111; e.seg1 = 8'hFF; e.fd1 = 1'b0;
            sb.push_back(e);
            t = 0; sh_d = '0; sh_p = '0;
            for (int k = 0; k < 2; k++) begin
                dd[k] = '0;
                ddp[k] = '0;
            end
            return;
        end
        r0 = expect_out(0);
        r1 = expect_out(1);
        e.fd0 = r0[12]; e.an0 = r0[11:8]; e.seg0 = r0[7:0];
        e.fd1 = r1[12]; e.an1 = r1[10:8]; e.seg1 = r1[7:0];
        sb.push_back(e);
        if (load) begin
            sh_d = data;
            sh_p = dp;
        end
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 1) ? 3 : 4;
            if (t % (16*n) == 16*n - 1) begin
                dd[k] = sh_d;
                ddp[k] = sh_p;
            end
        end
        t++;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load_once(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp = p;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("anodes0", {4'h0, an0}, {4'h0, e.an0});
            chk("seg0", seg0, e.seg0);
            chk("frame_done0", {7'h0, fd0}, {7'h0, e.fd0});
            chk("anodes1", {5'h0, an1}, {5'h0, e.an1});
            chk("seg1", seg1, e.seg1);
            chk("frame_done1", {7'h0, fd1}, {7'h0, e.fd1});
        end
    end

    initial begin
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        load_once(16'h1234, 4'h0);
        run(140);
        load_once(16'hAAAA, 4'h0);
        run(70);
        while ((t / 16) % 4 != 2) cyc();
        load_once(16'h5555, 4'h0);
        run(90);
        while (t % 64 != 63) cyc();
        load_once(16'hC0DE, 4'h5);
        run(70);
        blank_lz = 1'b1;
        load_once(16'h0070, 4'b1000);
        run(130);
        load_once(16'h0000, 4'h0);
        run(130);
        blank_lz = 1'b0;
        brightness = 2'd0;
        run(64);
        brightness = 2'd1;
        run(64);
        repeat (10) begin
            run(5);
            brightness = 2'($urandom_range(0, 3));
        end
        brightness = 2'd3;
        load_once(16'h4321, 4'h3);
        while ((t / 16) % 4 != 2) cyc();
        load_once(16'h9999, 4'hF);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run(80);
        repeat (2000) begin
            load = ($urandom_range(0, 19) == 0);
            data = 16'($urandom);
            dp = 4'($urandom);
            if ($urandom_range(0, 199) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 9) == 0) data[15:8] = 8'h00;
            cyc();
        end
        load = 1'b0;
        rst = 1'b0;
        run(2);
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
